// File: rtl/crcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crcu_pkg
// Description : Shared constants and types for the CRCU register slice.
// Revision    : 1.0 - initial release
// ============================================================================
package crcu_pkg;

    localparam logic [7:0]  ADDR_RST_CTL  = 8'h00;
    localparam logic [7:0]  ADDR_CLK_CTL  = 8'h04;
    localparam logic [7:0]  ADDR_STATUS   = 8'h08;
    localparam logic [7:0]  ADDR_ID       = 8'h0C;

    localparam int          SW_RST_BIT    = 0;
    localparam int          RST_MODE_LSB  = 1;
    localparam int          RST_MODE_W    = 2;
    localparam int          RST_DUR_LSB   = 3;
    localparam int          RST_DUR_W     = 16;
    localparam int          RST_IE_BIT    = 19;
    localparam int          CLK_DIV_LSB   = 0;
    localparam int          CLK_DIV_W     = 8;
    localparam int          CLK_GATE_BIT  = 8;
    localparam int          ST_ACTIVE_BIT = 0;
    localparam int          ST_DONE_BIT   = 1;

    localparam logic [RST_MODE_W-1:0] RST_MODE_RST = '0;
    localparam logic [CLK_DIV_W-1:0]  CLK_DIV_RST  = 8'h01;
    localparam logic [31:0]           CRCU_ID      = 32'h43524355;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_SETUP  = 2'd1,
        BUS_ACCESS = 2'd2
    } bus_state_t;

    // Zero is not a legal count downstream; it is promoted to one.
    function automatic logic [15:0] nz16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic logic [7:0] nz8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crcu_apb_regs_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : crcu_edge_det
// Description : Registers a level and emits a registered one-cycle fall pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module crcu_edge_det (
    input  logic CRCU_CLK,
    input  logic CRCU_RST_N,
    input  logic i_sig,
    output logic o_sig_q,
    output logic o_fall
);

    logic r_sig_q;
    logic r_fall;

    always_ff @(posedge CRCU_CLK) begin
        if (!CRCU_RST_N) begin
            r_sig_q <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sig_q <= i_sig;
            r_fall  <= r_sig_q & ~i_sig;
        end
    end

    assign o_sig_q = r_sig_q;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/crcu_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : crcu_apb_regs
// Description : APB3 control/status register block feeding the reset generator.
// Revision    : 1.0 - initial release
// ============================================================================
module crcu_apb_regs
    import crcu_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] DUR_RST     = 16'h0010
) (
    input  logic        CRCU_CLK,
    input  logic        CRCU_RST_N,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        rst_in,
    output logic [31:0] rst_ctl_reg,
    output logic [31:0] clk_ctl_reg,
    output logic        sw_rst_req,
    output logic        irq
);

    localparam logic [3:0] c_WAIT = WAIT_STATES[3:0];

    bus_state_t      r_state;
    logic [3:0]      r_wait_cnt;
    logic            r_pready;
    logic            r_pslverr;
    logic [31:0]     r_prdata;

    logic [RST_MODE_W-1:0] r_rst_mode;
    logic [RST_DUR_W-1:0]  r_rst_dur;
    logic                  r_ie;
    logic [CLK_DIV_W-1:0]  r_clk_div;
    logic                  r_clk_gate;
    logic                  r_rst_done;
    logic                  r_sw_rst;

    logic        w_rst_sync;
    logic        w_rst_fall;
    logic        w_addr_err;
    logic        w_wr_err;
    logic        w_err;
    logic        w_commit;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic        w_unused_pwdata;

    crcu_edge_det u_rst_edge (
        .CRCU_CLK   (CRCU_CLK),
        .CRCU_RST_N (CRCU_RST_N),
        .i_sig      (rst_in),
        .o_sig_q    (w_rst_sync),
        .o_fall     (w_rst_fall)
    );

    assign w_addr_err = (PADDR > ADDR_ID) || (PADDR[1:0] != 2'b00);
    assign w_wr_err   = PWRITE && ((PADDR == ADDR_ID) ||
                                   ((PADDR == ADDR_STATUS) && PWDATA[ST_ACTIVE_BIT]));
    assign w_err      = w_addr_err || w_wr_err;
    assign w_commit   = (r_state == BUS_ACCESS) && r_pready;
    assign w_wr       = w_commit && PWRITE && !w_err;

    always_comb begin
        w_rdata = '0;
        case (PADDR)
            ADDR_RST_CTL: begin
                w_rdata[RST_MODE_LSB +: RST_MODE_W] = r_rst_mode;
                w_rdata[RST_DUR_LSB +: RST_DUR_W]   = r_rst_dur;
                w_rdata[RST_IE_BIT]                 = r_ie;
            end
            ADDR_CLK_CTL: begin
                w_rdata[CLK_DIV_LSB +: CLK_DIV_W] = r_clk_div;
                w_rdata[CLK_GATE_BIT]             = r_clk_gate;
            end
            ADDR_STATUS: begin
                w_rdata[ST_ACTIVE_BIT] = w_rst_sync;
                w_rdata[ST_DONE_BIT]   = r_rst_done;
            end
            ADDR_ID:     w_rdata = CRCU_ID;
            default:     w_rdata = '0;
        endcase
    end

    // Bus handshake: response fields are registered and only non-zero while PREADY is high.
    always_ff @(posedge CRCU_CLK) begin
        if (!CRCU_RST_N) begin
            r_state    <= BUS_IDLE;
            r_wait_cnt <= '0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
            r_prdata   <= '0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (PSEL && !PENABLE)
                        r_state <= BUS_SETUP;
                end
                BUS_SETUP: begin
                    r_state    <= BUS_ACCESS;
                    r_wait_cnt <= '0;
                    if (c_WAIT == 4'd0) begin
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= PWRITE ? 32'd0 : w_rdata;
                    end
                end
                BUS_ACCESS: begin
                    if (r_pready) begin
                        r_pready   <= 1'b0;
                        r_pslverr  <= 1'b0;
                        r_prdata   <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= (PSEL && !PENABLE) ? BUS_SETUP : BUS_IDLE;
                    end else if (!PSEL) begin
                        r_state    <= BUS_IDLE;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                        if (r_wait_cnt + 4'd1 == c_WAIT) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= PWRITE ? 32'd0 : w_rdata;
                        end
                    end
                end
                default: r_state <= BUS_IDLE;
            endcase
        end
    end

    always_ff @(posedge CRCU_CLK) begin
        if (!CRCU_RST_N) begin
            r_rst_mode <= RST_MODE_RST;
            r_rst_dur  <= DUR_RST;
            r_ie       <= 1'b0;
            r_clk_div  <= CLK_DIV_RST;
            r_clk_gate <= 1'b0;
            r_rst_done <= 1'b0;
            r_sw_rst   <= 1'b0;
        end else begin
            r_sw_rst <= 1'b0;
            if (w_wr) begin
                case (PADDR)
                    ADDR_RST_CTL: begin
                        r_sw_rst   <= PWDATA[SW_RST_BIT];
                        r_rst_mode <= PWDATA[RST_MODE_LSB +: RST_MODE_W];
                        r_rst_dur  <= nz16(PWDATA[RST_DUR_LSB +: RST_DUR_W]);
                        r_ie       <= PWDATA[RST_IE_BIT];
                    end
                    ADDR_CLK_CTL: begin
                        r_clk_div  <= nz8(PWDATA[CLK_DIV_LSB +: CLK_DIV_W]);
                        r_clk_gate <= PWDATA[CLK_GATE_BIT];
                    end
                    default: ;
                endcase
            end
            // A completed reset outranks a simultaneous software clear.
            if (w_rst_fall)
                r_rst_done <= 1'b1;
            else if (w_wr && (PADDR == ADDR_STATUS) && PWDATA[ST_DONE_BIT])
                r_rst_done <= 1'b0;
        end
    end

    assign w_unused_pwdata = ^PWDATA[31:20];

    assign PRDATA      = r_prdata;
    assign PREADY      = r_pready;
    assign PSLVERR     = r_pslverr;
    assign rst_ctl_reg = {12'b0, r_ie, r_rst_dur, r_rst_mode, r_sw_rst};
    assign clk_ctl_reg = {23'b0, r_clk_gate, r_clk_div};
    assign sw_rst_req  = r_sw_rst;
    assign irq         = r_rst_done & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_crcu_apb_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_crcu_apb_regs
// Description : Directed self-checking bench for crcu_apb_regs (0 and 3 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crcu_apb_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel0, psel1, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic        rst_in;
    logic [31:0] prdata0, prdata1, rst_ctl0, rst_ctl1, clk_ctl0, clk_ctl1;
    logic        pready0, pready1, pslverr0, pslverr1, sw0, sw1, irq0, irq1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crcu_apb_regs #(.WAIT_STATES(0), .DUR_RST(16'h0010)) u_dut0 (
        .CRCU_CLK(clk), .CRCU_RST_N(rst_n), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .rst_in(rst_in), .rst_ctl_reg(rst_ctl0),
        .clk_ctl_reg(clk_ctl0), .sw_rst_req(sw0), .irq(irq0)
    );

    crcu_apb_regs #(.WAIT_STATES(3), .DUR_RST(16'h0010)) u_dut1 (
        .CRCU_CLK(clk), .CRCU_RST_N(rst_n), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1),
        .PREADY(pready1), .PSLVERR(pslverr1), .rst_in(rst_in), .rst_ctl_reg(rst_ctl1),
        .clk_ctl_reg(clk_ctl1), .sw_rst_req(sw1), .irq(irq1)
    );

    // One full APB transfer on DUT d; returns on the negedge after the commit edge.
    task automatic apb(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int waits);
        @(negedge clk);
        if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if ((d == 0) ? pready0 : pready1) break;
            waits++;
            if (waits > 20) begin
                total++; bad++;
                $display("FAIL apb_timeout addr=%h pready=0 required=1", a);
                break;
            end
        end
        rd  = (d == 0) ? prdata0 : prdata1;
        err = (d == 0) ? pslverr0 : pslverr1;
        @(negedge clk);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({pready0, pslverr0, prdata0, sw0, irq0} !== 36'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {pready0, pslverr0, prdata0, sw0, irq0});
        end
        total++;
        if (rst_ctl0 !== 32'h0000_0080 || clk_ctl0 !== 32'h0000_0001) begin
            bad++; $display("FAIL reset_ctl_ports got=%h/%h exp=00000080/00000001", rst_ctl0, clk_ctl0);
        end
        apb(0, 1'b0, 8'h00, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0080 || err !== 1'b0) begin
            bad++; $display("FAIL reset_rd_rst_ctl got=%h err=%b exp=00000080 err=0", rd, err);
        end
        apb(0, 1'b0, 8'h04, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0001 || err !== 1'b0) begin
            bad++; $display("FAIL reset_rd_clk_ctl got=%h err=%b exp=00000001 err=0", rd, err);
        end
        apb(0, 1'b0, 8'h08, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0000 || err !== 1'b0) begin
            bad++; $display("FAIL reset_rd_status got=%h err=%b exp=00000000 err=0", rd, err);
        end
        apb(0, 1'b0, 8'h0C, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h4352_4355 || err !== 1'b0 || w !== 0) begin
            bad++; $display("FAIL reset_rd_id got=%h err=%b waits=%0d exp=43524355 err=0 waits=0", rd, err, w);
        end
    endtask

    task automatic test_field_writes();
        logic [31:0] rd; logic err; int w;
        apb(0, 1'b1, 8'h00, 32'h0000_0005, rd, err, w);
        total++;
        if (sw0 !== 1'b1 || rst_ctl0 !== 32'h0000_000D || err !== 1'b0) begin
            bad++; $display("FAIL wr_sw_pulse sw=%b ctl=%h err=%b exp sw=1 ctl=0000000d err=0", sw0, rst_ctl0, err);
        end
        @(negedge clk);
        total++;
        if (sw0 !== 1'b0 || rst_ctl0 !== 32'h0000_000C) begin
            bad++; $display("FAIL wr_sw_one_cycle sw=%b ctl=%h exp sw=0 ctl=0000000c", sw0, rst_ctl0);
        end
        apb(0, 1'b0, 8'h00, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_000C) begin
            bad++; $display("FAIL wr_dur_zero_rd got=%h exp=0000000c", rd);
        end
        apb(0, 1'b1, 8'h00, 32'h0008_091A, rd, err, w);
        total++;
        if (sw0 !== 1'b0 || rst_ctl0 !== 32'h0008_091A) begin
            bad++; $display("FAIL wr_ie_dur sw=%b ctl=%h exp sw=0 ctl=0008091a", sw0, rst_ctl0);
        end
        apb(0, 1'b1, 8'h04, 32'h0000_0100, rd, err, w);
        apb(0, 1'b0, 8'h04, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0101 || clk_ctl0 !== 32'h0000_0101) begin
            bad++; $display("FAIL wr_div_zero rd=%h port=%h exp=00000101", rd, clk_ctl0);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int w;
        apb(1, 1'b1, 8'h04, 32'h0000_01FF, rd, err, w);
        total++;
        if (w !== 3 || err !== 1'b0 || clk_ctl1 !== 32'h0000_01FF) begin
            bad++; $display("FAIL ws_write waits=%0d err=%b ctl=%h exp waits=3 err=0 ctl=000001ff", w, err, clk_ctl1);
        end
        apb(1, 1'b0, 8'h0C, 32'd0, rd, err, w);
        total++;
        if (w !== 3 || rd !== 32'h4352_4355) begin
            bad++; $display("FAIL ws_read waits=%0d rd=%h exp waits=3 rd=43524355", w, rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w;
        apb(0, 1'b1, 8'h10, 32'hFFFF_FFFF, rd, err, w);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_range_wr err=%b exp=1", err); end
        apb(0, 1'b0, 8'h02, 32'd0, rd, err, w);
        total++;
        if (err !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL err_misaligned_rd err=%b rd=%h exp err=1 rd=0", err, rd);
        end
        apb(0, 1'b1, 8'h02, 32'h0000_0001, rd, err, w);
        total++;
        if (err !== 1'b1 || sw0 !== 1'b0 || rst_ctl0 !== 32'h0008_091A) begin
            bad++; $display("FAIL err_misaligned_wr err=%b sw=%b ctl=%h exp err=1 sw=0 ctl=0008091a", err, sw0, rst_ctl0);
        end
        apb(0, 1'b1, 8'h0C, 32'h0000_0000, rd, err, w);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_write_id err=%b exp=1", err); end
        apb(0, 1'b1, 8'h08, 32'h0000_0001, rd, err, w);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_status_bit0 err=%b exp=1", err); end
        apb(0, 1'b0, 8'h04, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0101 || err !== 1'b0) begin
            bad++; $display("FAIL err_no_change rd=%h err=%b exp rd=00000101 err=0", rd, err);
        end
        // Abandon a waited write on DUT1 by dropping PSEL during ACCESS.
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0000_0023;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        @(negedge clk); psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (clk_ctl1 !== 32'h0000_01FF || pready1 !== 1'b0) begin
            bad++; $display("FAIL psel_drop ctl=%h pready=%b exp ctl=000001ff pready=0", clk_ctl1, pready1);
        end
    endtask

    task automatic test_status();
        logic [31:0] rd; logic err; int w;
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        apb(0, 1'b0, 8'h08, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0001 || irq0 !== 1'b0) begin
            bad++; $display("FAIL st_active rd=%h irq=%b exp rd=00000001 irq=0", rd, irq0);
        end
        rst_in = 1'b0;
        @(negedge clk);
        total++;
        if (irq0 !== 1'b0) begin bad++; $display("FAIL st_irq_early irq=%b exp=0", irq0); end
        @(negedge clk);
        total++;
        if (irq0 !== 1'b1) begin bad++; $display("FAIL st_irq_set irq=%b exp=1", irq0); end
        apb(0, 1'b0, 8'h08, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0002) begin bad++; $display("FAIL st_done_rd got=%h exp=00000002", rd); end
        // W1C commit edge coincides with the set edge of a second fall.
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0000_0002;
        @(negedge clk); penable = 1'b1; rst_in = 1'b0;
        @(negedge clk);
        total++;
        if (pready0 !== 1'b1 || pslverr0 !== 1'b0) begin
            bad++; $display("FAIL st_coll_ready pready=%b err=%b exp pready=1 err=0", pready0, pslverr0);
        end
        @(negedge clk); psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        total++;
        if (irq0 !== 1'b1) begin bad++; $display("FAIL st_set_wins irq=%b exp=1", irq0); end
        apb(0, 1'b1, 8'h08, 32'h0000_0002, rd, err, w);
        total++;
        if (irq0 !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL st_w1c irq=%b err=%b exp irq=0 err=0", irq0, err);
        end
        apb(0, 1'b0, 8'h08, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0000) begin bad++; $display("FAIL st_cleared_rd got=%h exp=00000000", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w;
        @(negedge clk);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000_0005;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        total++;
        if (pready1 !== 1'b0) begin bad++; $display("FAIL mid_in_wait pready=%b exp=0", pready1); end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (pready1 !== 1'b0 || sw1 !== 1'b0 || rst_ctl1 !== 32'h0000_0080 || clk_ctl1 !== 32'h0000_0001) begin
            bad++; $display("FAIL mid_reset pready=%b sw=%b rst=%h clk=%h exp 0/0/00000080/00000001",
                            pready1, sw1, rst_ctl1, clk_ctl1);
        end
        total++;
        if (rst_ctl0 !== 32'h0000_0080 || clk_ctl0 !== 32'h0000_0001 || irq0 !== 1'b0) begin
            bad++; $display("FAIL mid_reset_dut0 rst=%h clk=%h irq=%b exp 00000080/00000001/0", rst_ctl0, clk_ctl0, irq0);
        end
        psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0; rst_n = 1'b1;
        apb(1, 1'b0, 8'h00, 32'd0, rd, err, w);
        total++;
        if (rd !== 32'h0000_0080 || w !== 3) begin
            bad++; $display("FAIL mid_after_rd rd=%h waits=%0d exp rd=00000080 waits=3", rd, w);
        end
    endtask

    initial begin
        rst_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 32'd0; rst_in = 1'b0;
        test_reset();
        test_field_writes();
        test_wait_states();
        test_errors();
        test_status();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
